// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate-block self-test sequencer.
package gate_sweep_pkg;

    localparam int unsigned NUM_GATES = 7;
    localparam int unsigned NUM_VECS  = 4;
    localparam int unsigned VEC_W     = 2;

    localparam int unsigned GATE_AND  = 0;
    localparam int unsigned GATE_OR   = 1;
    localparam int unsigned GATE_NOTA = 2;
    localparam int unsigned GATE_NAND = 3;
    localparam int unsigned GATE_NOR  = 4;
    localparam int unsigned GATE_XOR  = 5;
    localparam int unsigned GATE_XNOR = 6;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    // Number of set bits in a gate vector (0..7).
    function automatic logic [2:0] popcount_gates(input gate_vec_t v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < int'(NUM_GATES); i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Stimulus/observation bus between the sweep sequencer and its environment.
interface gate_sweep_ctrl_if #(
    parameter int unsigned ERR_W = 4
);
    import gate_sweep_pkg::*;

    logic             start;
    logic             a_o;
    logic             b_o;
    gate_vec_t        gate_i;
    logic             busy;
    logic             done;
    logic             pass;
    gate_vec_t        err_mask;
    logic [ERR_W-1:0] err_count;

    // Environment side: requests sweeps and returns the gate outputs.
    modport master (
        output start,
        output gate_i,
        input  a_o,
        input  b_o,
        input  busy,
        input  done,
        input  pass,
        input  err_mask,
        input  err_count
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  gate_i,
        output a_o,
        output b_o,
        output busy,
        output done,
        output pass,
        output err_mask,
        output err_count
    );

endinterface

// File: rtl/gate_golden_model.sv
// Combinational reference for the seven basic gates, same bit order as gate_i.
module gate_golden_model
    import gate_sweep_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    output gate_vec_t expected_c_o
);

    always_comb begin
        expected_c_o            = '0;
        expected_c_o[GATE_AND]  = a_i & b_i;
        expected_c_o[GATE_OR]   = a_i | b_i;
        expected_c_o[GATE_NOTA] = ~a_i;
        expected_c_o[GATE_NAND] = ~(a_i & b_i);
        expected_c_o[GATE_NOR]  = ~(a_i | b_i);
        expected_c_o[GATE_XOR]  = a_i ^ b_i;
        expected_c_o[GATE_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Deterministic a/b sweep of the gate block with golden-model checking.
// Optional first-failure capture ports enabled by GATE_SWEEP_FIRST_FAIL_EN.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    output logic                 ff_valid,
    output logic [VEC_W-1:0]     ff_vec,
`endif
    gate_sweep_ctrl_if.slave     bus
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    gate_vec_t        err_mask_q, err_mask_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    gate_vec_t        expected_c, mism_c;
    logic [SUM_W-1:0] sum_c;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [VEC_W-1:0] ff_vec_q, ff_vec_d;
`endif

    gate_golden_model u_golden (
        .a_i          (a_q),
        .b_i          (b_q),
        .expected_c_o (expected_c)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_mask_d  = err_mask_q;
        err_count_d = err_count_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        ff_valid_d  = ff_valid_q;
        ff_vec_d    = ff_vec_q;
`endif
        mism_c      = bus.gate_i ^ expected_c;
        sum_c       = SUM_W'(err_count_q) + SUM_W'(popcount_gates(mism_c));

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_mask_d  = '0;
                    err_count_d = '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                    ff_valid_d  = 1'b0;
                    ff_vec_d    = '0;
`endif
                end
            end
            DRIVE: begin
                cnt_d   = CNT_LOAD;
                state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                // Accumulate mismatches; count clamps instead of wrapping.
                err_mask_d  = err_mask_q | mism_c;
                err_count_d = (sum_c > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(sum_c);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                if ((mism_c != '0) && !ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_vec_d   = vec_q;
                end
`endif
                if (vec_q == VEC_W'(NUM_VECS - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d      = DRIVE;
                    vec_d        = vec_q + VEC_W'(1);
                    {a_d, b_d}   = vec_q + VEC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= '0;
            err_count_q <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_mask_q  <= err_mask_d;
            err_count_q <= err_count_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_valid_q  <= ff_valid_d;
            ff_vec_q    <= ff_vec_d;
`endif
        end
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_mask  = err_mask_q;
    assign bus.err_count = err_count_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    assign ff_valid      = ff_valid_q;
    assign ff_vec        = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: S=1 and S=0 instances, injected gate faults.
module tb_gate_sweep_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   mode;

    gate_sweep_ctrl_if #(.ERR_W(4)) bus1 ();
    gate_sweep_ctrl_if #(.ERR_W(4)) bus0 ();

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic       ff_valid1, ff_valid0;
    logic [1:0] ff_vec1, ff_vec0;
`endif

    gate_sweep_ctrl #(.SETTLE_CYCLES(1), .ERR_W(4)) dut1 (
        .clk      (clk),
        .rst      (rst),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .ff_valid (ff_valid1),
        .ff_vec   (ff_vec1),
`endif
        .bus      (bus1)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(0), .ERR_W(4)) dut0 (
        .clk      (clk),
        .rst      (rst),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .ff_valid (ff_valid0),
        .ff_vec   (ff_vec0),
`endif
        .bus      (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written truth table, bits {z,y,x,w,v,u,t}.
    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 7'h5C;
            2'b01:   return 7'h2E;
            2'b10:   return 7'h2A;
            default: return 7'h43;
        endcase
    endfunction

    // Gate block model with selectable faults: 1 XOR stuck-0, 2 inverted, 3 NOR stuck-1.
    always_comb begin
        case (mode)
            1:       bus1.gate_i = ref_gates(bus1.a_o, bus1.b_o) & ~7'h20;
            2:       bus1.gate_i = ~ref_gates(bus1.a_o, bus1.b_o);
            3:       bus1.gate_i = ref_gates(bus1.a_o, bus1.b_o) | 7'h10;
            default: bus1.gate_i = ref_gates(bus1.a_o, bus1.b_o);
        endcase
        bus0.gate_i = ref_gates(bus0.a_o, bus0.b_o);
    end

    // Pulse start on dut1 and wait for done; optionally re-pulse start mid-sweep.
    task automatic run_sweep(input bit repulse, output int edges, output logic [7:0] seq);
        logic [2:0] last;
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        edges = 0;
        seq   = 8'h00;
        last  = 3'b100;
        if (bus1.busy) begin
            seq  = {seq[5:0], bus1.a_o, bus1.b_o};
            last = {1'b0, bus1.a_o, bus1.b_o};
        end
        while (!bus1.done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            bus1.start = (repulse && edges == 4);
            if (bus1.busy && ({1'b0, bus1.a_o, bus1.b_o} != last)) begin
                seq  = {seq[5:0], bus1.a_o, bus1.b_o};
                last = {1'b0, bus1.a_o, bus1.b_o};
            end
        end
        bus1.start = 1'b0;
        vectors++;
        if (!bus1.done) begin
            miscompares++;
            $display("FAIL sweep_timeout: done=%0b after %0d edges, required done=1", bus1.done, edges);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus1.a_o, bus1.b_o, bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_s1: outputs=%h required 0", {bus1.a_o, bus1.b_o, bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count});
        end
        vectors++;
        if ({bus0.a_o, bus0.b_o, bus0.busy, bus0.done, bus0.pass, bus0.err_mask, bus0.err_count} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_s0: outputs=%h required 0", {bus0.a_o, bus0.b_o, bus0.busy, bus0.done, bus0.pass, bus0.err_mask, bus0.err_count});
        end
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        vectors++;
        if ({ff_valid1, ff_vec1} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ff: ff=%b required 000", {ff_valid1, ff_vec1});
        end
`endif
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int         edges;
        logic [7:0] seq;
        mode = 0;
        run_sweep(1'b0, edges, seq);
        vectors++;
        if (edges !== 12) begin
            miscompares++;
            $display("FAIL clean_latency: edges=%0d required 12", edges);
        end
        vectors++;
        if (seq !== 8'h1B) begin
            miscompares++;
            $display("FAIL clean_ab_order: seq=%h required 1b", seq);
        end
        vectors++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count} !== {3'b011, 7'h00, 4'd0}) begin
            miscompares++;
            $display("FAIL clean_result: busy/done/pass=%b mask=%h count=%0d required 011/00/0",
                     {bus1.busy, bus1.done, bus1.pass}, bus1.err_mask, bus1.err_count);
        end
        vectors++;
        if ({bus1.a_o, bus1.b_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL done_hold_ab: ab=%b required 11", {bus1.a_o, bus1.b_o});
        end
    endtask

    task automatic test_xor_stuck();
        int         edges;
        logic [7:0] seq;
        mode = 1;
        run_sweep(1'b0, edges, seq);
        vectors++;
        if ({bus1.pass, bus1.err_mask, bus1.err_count} !== {1'b0, 7'h20, 4'd2}) begin
            miscompares++;
            $display("FAIL xor_stuck: pass=%b mask=%h count=%0d required 0/20/2", bus1.pass, bus1.err_mask, bus1.err_count);
        end
    endtask

    task automatic test_inverted();
        int         edges;
        logic [7:0] seq;
        mode = 2;
        run_sweep(1'b0, edges, seq);
        vectors++;
        if ({bus1.pass, bus1.err_mask, bus1.err_count} !== {1'b0, 7'h7F, 4'd15}) begin
            miscompares++;
            $display("FAIL inverted_saturate: pass=%b mask=%h count=%0d required 0/7f/15", bus1.pass, bus1.err_mask, bus1.err_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int         edges;
        logic [7:0] seq;
        mode = 2;
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({bus1.busy, bus1.a_o, bus1.b_o, bus1.err_count} !== {3'b110, 4'd14}) begin
            miscompares++;
            $display("FAIL mid_sweep_state: busy/a/b=%b count=%0d required 110/14", {bus1.busy, bus1.a_o, bus1.b_o}, bus1.err_count);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus1.a_o, bus1.b_o, bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count} !== 15'h0) begin
            miscompares++;
            $display("FAIL mid_sweep_reset: outputs=%h required 0", {bus1.a_o, bus1.b_o, bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count});
        end
        @(negedge clk) rst = 1'b0;
        mode = 0;
        run_sweep(1'b0, edges, seq);
        vectors++;
        if ({edges, bus1.pass, bus1.err_count} !== {32'd12, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL post_reset_sweep: edges=%0d pass=%b count=%0d required 12/1/0", edges, bus1.pass, bus1.err_count);
        end
    endtask

    task automatic test_restart();
        int         edges;
        logic [7:0] seq;
        mode = 1;
        run_sweep(1'b1, edges, seq);
        vectors++;
        if ({edges, bus1.err_count, bus1.err_mask} !== {32'd12, 4'd2, 7'h20}) begin
            miscompares++;
            $display("FAIL start_while_busy: edges=%0d count=%0d mask=%h required 12/2/20", edges, bus1.err_count, bus1.err_mask);
        end
        mode = 0;
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        vectors++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.err_count} !== {3'b100, 7'h00, 4'd0}) begin
            miscompares++;
            $display("FAIL restart_clear: busy/done/pass=%b mask=%h count=%0d required 100/00/0",
                     {bus1.busy, bus1.done, bus1.pass}, bus1.err_mask, bus1.err_count);
        end
        edges = 0;
        while (!bus1.done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        vectors++;
        if ({edges, bus1.pass} !== {32'd12, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_rerun: edges=%0d pass=%b required 12/1", edges, bus1.pass);
        end
    endtask

    task automatic test_zero_settle();
        int edges;
        @(negedge clk) bus0.start = 1'b1;
        @(negedge clk) bus0.start = 1'b0;
        edges = 0;
        while (!bus0.done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        vectors++;
        if ({edges, bus0.busy, bus0.pass, bus0.err_count} !== {32'd8, 1'b0, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL zero_settle: edges=%0d busy=%b pass=%b count=%0d required 8/0/1/0", edges, bus0.busy, bus0.pass, bus0.err_count);
        end
    endtask

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    task automatic test_first_fail();
        int         edges;
        logic [7:0] seq;
        mode = 3;
        run_sweep(1'b0, edges, seq);
        vectors++;
        if ({ff_valid1, ff_vec1, bus1.err_count, bus1.err_mask} !== {1'b1, 2'b01, 4'd3, 7'h10}) begin
            miscompares++;
            $display("FAIL first_fail: ff_valid=%b ff_vec=%b count=%0d mask=%h required 1/01/3/10",
                     ff_valid1, ff_vec1, bus1.err_count, bus1.err_mask);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        rst         = 1'b1;
        bus1.start  = 1'b0;
        bus0.start  = 1'b0;
        test_reset();
        test_clean_sweep();
        test_xor_stuck();
        test_inverted();
        test_reset_mid_sweep();
        test_restart();
        test_zero_settle();
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        test_first_fail();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
